// File: rtl/decade_counter.sv
// ============================================================================
// decade_counter : modulo-MODULUS up-counter with load, enable and terminal
// count. Optional seven-segment decode enabled by DECADE_COUNTER_SEG7_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decade_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
`ifdef DECADE_COUNTER_SEG7_EN
  ,
  output logic [6:0]       seg
`endif
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             w_at_max;

  assign w_at_max = (q_q == C_MAX);

  // Out-of-range load values collapse to 0 so q never leaves 0..MODULUS-1.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val <= C_MAX) ? load_val : '0;
    end else if (en) begin
      q_d = w_at_max ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  // Left combinational so a cascaded stage advances on the same edge.
  assign tc = en & w_at_max;

`ifdef DECADE_COUNTER_SEG7_EN
  logic [31:0] w_q_ext;

  assign w_q_ext = 32'(q_q);

  always_comb begin
    seg = 7'b0000000;
    case (w_q_ext)
      0:       seg = 7'b0111111;
      1:       seg = 7'b0000110;
      2:       seg = 7'b1011011;
      3:       seg = 7'b1001111;
      4:       seg = 7'b1100110;
      5:       seg = 7'b1101101;
      6:       seg = 7'b1111101;
      7:       seg = 7'b0000111;
      8:       seg = 7'b1111111;
      9:       seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_decade_counter.sv
// ============================================================================
// tb_decade_counter : directed self-checking bench for decade_counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decade_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc;

  logic       reset_c;
  logic [3:0] q0;
  logic [3:0] q1;
  logic       tc0;
  logic       tc1;

  int n_vec;
  int n_miss;

`ifdef DECADE_COUNTER_SEG7_EN
  logic [6:0] seg;
  logic [6:0] seg0;
  logic [6:0] seg1;
`endif

  decade_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc)
`ifdef DECADE_COUNTER_SEG7_EN
    ,
    .seg      (seg)
`endif
  );

  decade_counter #(.WIDTH(4), .MODULUS(10)) u_stage0 (
    .clk      (clk),
    .reset    (reset_c),
    .en       (1'b1),
    .load     (1'b0),
    .load_val (4'd0),
    .q        (q0),
    .tc       (tc0)
`ifdef DECADE_COUNTER_SEG7_EN
    ,
    .seg      (seg0)
`endif
  );

  decade_counter #(.WIDTH(4), .MODULUS(10)) u_stage1 (
    .clk      (clk),
    .reset    (reset_c),
    .en       (tc0),
    .load     (1'b0),
    .load_val (4'd0),
    .q        (q1),
    .tc       (tc1)
`ifdef DECADE_COUNTER_SEG7_EN
    ,
    .seg      (seg1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    reset    = 1'b0;
    reset_c  = 1'b0;
    en       = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;

    // Reset with en high, then free count with wrap 9 -> 0.
    tick();
    check("reset_q", int'(q), 0);
    check("reset_tc", int'(tc), 0);
    reset = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("count_q", int'(q), i % 10);
      check("count_tc", int'(tc), ((i % 10) == 9) ? 1 : 0);
    end

    // Count to 4, then reset wins over load and en.
    for (int i = 0; i < 3; i++) tick();
    check("pre_reset_q", int'(q), 4);
    reset    = 1'b0;
    load     = 1'b1;
    load_val = 4'd5;
    tick();
    check("midreset_q", int'(q), 0);
    tick();
    check("held_reset_q", int'(q), 0);
    reset = 1'b1;
    load  = 1'b0;
    tick();
    check("resume1_q", int'(q), 1);
    tick();
    check("resume2_q", int'(q), 2);

    // Hold at 6 with en low.
    for (int i = 0; i < 4; i++) tick();
    check("at6_q", int'(q), 6);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_q", int'(q), 6);
      check("hold_tc", int'(tc), 0);
    end
    en = 1'b1;
    tick();
    check("unhold_q", int'(q), 7);

    // Loads, including out-of-range values and load over en.
    load     = 1'b1;
    load_val = 4'd3;
    tick();
    check("load3_q", int'(q), 3);
    load_val = 4'd7;
    tick();
    check("load7_q", int'(q), 7);
    load_val = 4'd12;
    tick();
    check("load12_q", int'(q), 0);
    load_val = 4'd9;
    en       = 1'b0;
    tick();
    check("load9_q", int'(q), 9);
    check("tc_en0", int'(tc), 0);
    en = 1'b1;
    #1;
    check("tc_en1", int'(tc), 1);
    load_val = 4'd10;
    tick();
    check("load10_q", int'(q), 0);
    load_val = 4'd15;
    tick();
    check("load15_q", int'(q), 0);
    load = 1'b0;
    tick();
    check("after_load_q", int'(q), 1);

    // Two-stage cascade: stage1 steps only when stage0 wraps.
    reset_c = 1'b0;
    tick();
    check("casc_reset", int'({q1, q0}), 0);
    reset_c = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      check("casc_s0", int'(q0), k % 10);
      check("casc_s1", int'(q1), k / 10);
    end

`ifdef DECADE_COUNTER_SEG7_EN
    begin
      logic [6:0] seg_tab [10];
      seg_tab[0] = 7'b0111111;
      seg_tab[1] = 7'b0000110;
      seg_tab[2] = 7'b1011011;
      seg_tab[3] = 7'b1001111;
      seg_tab[4] = 7'b1100110;
      seg_tab[5] = 7'b1101101;
      seg_tab[6] = 7'b1111101;
      seg_tab[7] = 7'b0000111;
      seg_tab[8] = 7'b1111111;
      seg_tab[9] = 7'b1101111;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("seg_q0", int'(seg), int'(seg_tab[0]));
      for (int i = 1; i <= 9; i++) begin
        tick();
        check("seg_q", int'(seg), int'(seg_tab[i]));
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
